fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch/decode sequencer for the basic computer; sits directly upstream of the program counter and drives its INR/Load controls.
- Runs T0–T3 of the fetch cycle: AR←PC, IR←M[AR] with PC+1, decode, optional indirect read.
- Holds the decoded instruction for the execute unit and applies its skip/jump requests to the PC.

Parameters:
AW, 12, address width (PC/AR)
DW, 16, memory word / IR width
ACK_TIMEOUT, 15, max cycles to wait for MEM_ACK before fault

Ports:
CLK  input  1  rising-edge clock
CLR  input  1  asynchronous active-low reset
START  input  1  level; 1 = run, 0 = stop at next T0 boundary
MEM_DATA  input  DW  memory read data, valid with MEM_ACK
MEM_ACK  input  1  one-cycle read acknowledge
PC_Q  input  AW  current PC value
EXEC_DONE  input  1  execute unit finished; restart fetch
SKIP  input  1  execute unit requests PC+1 (skip)
JMP_REQ  input  1  execute unit requests PC load
JMP_ADDR  input  AW  jump target
MEM_RD  output  1  read request, held until MEM_ACK
AR  output  AW  address register (memory address)
IR  output  DW  instruction register
I  output  1  indirect bit IR[15]
D  output  8  one-hot opcode decode of IR[14:12]
T  output  16  one-hot timing signal, T[SC]
PC_INR  output  1  one-cycle PC increment
PC_LOAD  output  1  one-cycle PC load
PC_DATA  output  AW  PC load data
DEC_VALID  output  1  instruction decoded, AR holds effective address
FAULT  output  1  sticky: memory ack timeout

Behaviour:
- Reset (CLR=0, async): state IDLE, SC=0, AR=0, IR=0, I=0, D=0, all strobes 0, DEC_VALID=0, FAULT=0; T=16'h0001.
- SC: 4-bit, increments on every state advance, cleared to 0 on entry to T0; T = one-hot of SC; SC saturates at 15 (no wrap).
- States:
  - IDLE: leave for T0 when START=1 and FAULT=0.
  - T0: AR←PC_Q (1 cycle), then FETCH.
  - FETCH: MEM_RD=1 with AR stable; on MEM_ACK, IR←MEM_DATA and PC_INR=1 for exactly that cycle, then DECODE. Wait cycles do not advance SC.
  - DECODE: AR←IR[11:0], I←IR[15], D←onehot(IR[14:12]). Next state is INDIR if I=1 and IR[14:12]≠7, else EXEC.
  - INDIR: MEM_RD=1; on MEM_ACK, AR←MEM_DATA[11:0], then EXEC.
  - EXEC: DEC_VALID=1. On EXEC_DONE go to T0 if START=1, else IDLE.
- Memory handshake: MEM_RD asserts on state entry and drops the cycle after MEM_ACK. MEM_ACK outside FETCH/INDIR is ignored.
- Timeout: a wait counter counts cycles with MEM_RD=1 and no ack. When it reaches ACK_TIMEOUT: FAULT=1, MEM_RD=0, go to IDLE. FAULT clears only on reset.
- PC control in EXEC:
  - JMP_REQ=1: PC_LOAD=1 and PC_DATA=JMP_ADDR for 1 cycle.
  - else SKIP=1: PC_INR=1 for 1 cycle.
  - Both set: jump wins, skip dropped.
  - Requests are edge-free levels and are sampled once per EXEC cycle; EXEC_DONE in the same cycle is still honoured.
  - Requests outside EXEC are ignored.
- Invariant: PC_INR and PC_LOAD are never 1 in the same cycle (the PC enables on Load XOR INR).
- START falling mid-instruction: the current instruction completes; stop happens at the T0 boundary.
- Reset mid-read: MEM_RD drops asynchronously; no PC strobe is emitted.

Test Plan:
- Reset, START=1, PC_Q=0x010, ack after 2 cycles with MEM_DATA=0x2345 -> AR=0x010 in T0; MEM_RD high 3 cycles; IR=0x2345; PC_INR one pulse; then AR=0x345, I=0, D=8'b0000_0100, DEC_VALID=1, T=T[3].
- MEM_DATA=0x9123, indirect read returns 0x0ABC -> I=1, D[1]=1, second MEM_RD, AR=0x0ABC, DEC_VALID.
- MEM_DATA=0xF800 (I=1, opcode 7) -> no INDIR state; EXEC directly; AR=0x800.
- In EXEC, JMP_REQ=1 with JMP_ADDR=0x0FF and SKIP=1 together -> PC_LOAD=1, PC_DATA=0x0FF, PC_INR=0 that cycle; then EXEC_DONE -> T0, SC=0.
- MEM_ACK withheld for ACK_TIMEOUT cycles -> FAULT=1, MEM_RD=0, IDLE; START held high stays IDLE until CLR pulse.
- START dropped during FETCH, then EXEC_DONE -> IDLE; CLR asserted mid-FETCH -> all outputs reset immediately, no PC_INR.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bundle: memory read handshake, PC controls, execute-unit
// requests and the decoded-instruction view. master = sequencer side.
interface fetch_ctrl_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
);
    logic          i_start;
    logic [DW-1:0] i_mem_data;
    logic          i_mem_ack;
    logic [AW-1:0] i_pc_q;
    logic          i_exec_done;
    logic          i_skip;
    logic          i_jmp_req;
    logic [AW-1:0] i_jmp_addr;

    logic          o_mem_rd;
    logic [AW-1:0] o_ar;
    logic [DW-1:0] o_ir;
    logic          o_i;
    logic [7:0]    o_d;
    logic [15:0]   o_t;
    logic          o_pc_inr;
    logic          o_pc_load;
    logic [AW-1:0] o_pc_data;
    logic          o_dec_valid;
    logic          o_fault;

    modport master (
        input  i_start, i_mem_data, i_mem_ack, i_pc_q, i_exec_done,
               i_skip, i_jmp_req, i_jmp_addr,
        output o_mem_rd, o_ar, o_ir, o_i, o_d, o_t, o_pc_inr, o_pc_load,
               o_pc_data, o_dec_valid, o_fault
    );

    modport slave (
        output i_start, i_mem_data, i_mem_ack, i_pc_q, i_exec_done,
               i_skip, i_jmp_req, i_jmp_addr,
        input  o_mem_rd, o_ar, o_ir, o_i, o_d, o_t, o_pc_inr, o_pc_load,
               o_pc_data, o_dec_valid, o_fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode sequencer: T0 AR<-PC, IR<-M[AR] with PC+1,
// decode, optional indirect read, then hand off to execute and apply skip/jump.
module fetch_ctrl #(
    parameter int unsigned AW          = 12,
    parameter int unsigned DW          = 16,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_clr_n,
    fetch_ctrl_if.master bus
);
    localparam int unsigned SCW = 4;
    localparam int unsigned WCW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_FETCH, S_DECODE, S_INDIR, S_EXEC
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [SCW-1:0]  r_sc, w_sc_nxt;
    logic [15:0]     r_t, w_t_nxt;
    logic [WCW-1:0]  r_wait, w_wait_nxt;
    logic [AW-1:0]   r_ar, w_ar_nxt;
    logic [DW-1:0]   r_ir, w_ir_nxt;
    logic            r_i, w_i_nxt;
    logic [7:0]      r_d, w_d_nxt;
    logic            r_mem_rd, w_mem_rd_nxt;
    logic            r_pc_inr, w_pc_inr_nxt;
    logic            r_pc_load, w_pc_load_nxt;
    logic [AW-1:0]   r_pc_data, w_pc_data_nxt;
    logic            r_dec_valid, w_dec_valid_nxt;
    logic            r_fault, w_fault_nxt;
    logic [2:0]      w_opcode;

    assign w_opcode = r_ir[DW-2 -: 3];

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state     <= S_IDLE;
            r_sc        <= '0;
            r_t         <= 16'h0001;
            r_wait      <= '0;
            r_ar        <= '0;
            r_ir        <= '0;
            r_i         <= 1'b0;
            r_d         <= '0;
            r_mem_rd    <= 1'b0;
            r_pc_inr    <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_data   <= '0;
            r_dec_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sc        <= w_sc_nxt;
            r_t         <= w_t_nxt;
            r_wait      <= w_wait_nxt;
            r_ar        <= w_ar_nxt;
            r_ir        <= w_ir_nxt;
            r_i         <= w_i_nxt;
            r_d         <= w_d_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_pc_inr    <= w_pc_inr_nxt;
            r_pc_load   <= w_pc_load_nxt;
            r_pc_data   <= w_pc_data_nxt;
            r_dec_valid <= w_dec_valid_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sc_nxt      = r_sc;
        w_wait_nxt    = r_wait;
        w_ar_nxt      = r_ar;
        w_ir_nxt      = r_ir;
        w_i_nxt       = r_i;
        w_d_nxt       = r_d;
        w_mem_rd_nxt  = r_mem_rd;
        w_pc_inr_nxt  = 1'b0;
        w_pc_load_nxt = 1'b0;
        w_pc_data_nxt = r_pc_data;
        w_fault_nxt   = r_fault;

        case (r_state)
            S_IDLE: begin
                if (bus.i_start && !r_fault) w_state_nxt = S_T0;
            end
            S_T0: begin
                w_ar_nxt     = bus.i_pc_q;
                w_mem_rd_nxt = 1'b1;
                w_wait_nxt   = '0;
                w_state_nxt  = S_FETCH;
            end
            S_FETCH, S_INDIR: begin
                // Same handshake for both reads; only the capture differs.
                if (bus.i_mem_ack) begin
                    w_mem_rd_nxt = 1'b0;
                    w_wait_nxt   = '0;
                    if (r_state == S_FETCH) begin
                        w_ir_nxt     = bus.i_mem_data;
                        w_pc_inr_nxt = 1'b1;
                        w_state_nxt  = S_DECODE;
                    end else begin
                        w_ar_nxt    = bus.i_mem_data[AW-1:0];
                        w_state_nxt = S_EXEC;
                    end
                end else if (r_wait == WCW'(ACK_TIMEOUT - 1)) begin
                    w_fault_nxt  = 1'b1;
                    w_mem_rd_nxt = 1'b0;
                    w_wait_nxt   = '0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_wait_nxt = r_wait + WCW'(1);
                end
            end
            S_DECODE: begin
                w_ar_nxt = r_ir[AW-1:0];
                w_i_nxt  = r_ir[DW-1];
                w_d_nxt  = 8'(1) << w_opcode;
                // Opcode 7 is register/IO class: the I bit is not indirection.
                if (r_ir[DW-1] && (w_opcode != 3'd7)) begin
                    w_mem_rd_nxt = 1'b1;
                    w_wait_nxt   = '0;
                    w_state_nxt  = S_INDIR;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.i_jmp_req) begin
                    w_pc_load_nxt = 1'b1;
                    w_pc_data_nxt = bus.i_jmp_addr;
                end else if (bus.i_skip) begin
                    w_pc_inr_nxt = 1'b1;
                end
                if (bus.i_exec_done) w_state_nxt = bus.i_start ? S_T0 : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt != r_state) begin
            if (w_state_nxt == S_T0)  w_sc_nxt = '0;
            else if (r_sc != 4'hF)    w_sc_nxt = r_sc + 4'd1;
        end
        w_t_nxt         = 16'(1) << w_sc_nxt;
        w_dec_valid_nxt = (w_state_nxt == S_EXEC);
    end

    assign bus.o_mem_rd    = r_mem_rd;
    assign bus.o_ar        = r_ar;
    assign bus.o_ir        = r_ir;
    assign bus.o_i         = r_i;
    assign bus.o_d         = r_d;
    assign bus.o_t         = r_t;
    assign bus.o_pc_inr    = r_pc_inr;
    assign bus.o_pc_load   = r_pc_load;
    assign bus.o_pc_data   = r_pc_data;
    assign bus.o_dec_valid = r_dec_valid;
    assign bus.o_fault     = r_fault;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: fetch, indirect, opcode-7, jump/skip,
// START drop, ack timeout and asynchronous reset mid-read.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic clr_n;
    int   errs   = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.AW(12), .DW(16)) bus ();

    fetch_ctrl #(.AW(12), .DW(16), .ACK_TIMEOUT(15)) dut (
        .i_clk   (clk),
        .i_clr_n (clr_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic [15:0] data);
        bus.i_mem_ack  = 1'b1;
        bus.i_mem_data = data;
        tick();
        bus.i_mem_ack  = 1'b0;
    endtask

    initial begin
        int n;
        clr_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_mem_data  = '0;
        bus.i_mem_ack   = 1'b0;
        bus.i_pc_q      = '0;
        bus.i_exec_done = 1'b0;
        bus.i_skip      = 1'b0;
        bus.i_jmp_req   = 1'b0;
        bus.i_jmp_addr  = '0;
        #12;
        chk("rst_ar", 32'(bus.o_ar), 32'h0);
        chk("rst_ir", 32'(bus.o_ir), 32'h0);
        chk("rst_t", 32'(bus.o_t), 32'h0001);
        chk("rst_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        chk("rst_fault", 32'(bus.o_fault), 32'h0);
        chk("rst_dec_valid", 32'(bus.o_dec_valid), 32'h0);
        clr_n = 1'b1;

        // Plain fetch, two wait cycles, opcode 2 direct
        bus.i_pc_q  = 12'h010;
        bus.i_start = 1'b1;
        tick();
        chk("t0_t", 32'(bus.o_t), 32'h0001);
        tick();
        chk("f1_ar", 32'(bus.o_ar), 32'h010);
        chk("f1_mem_rd", 32'(bus.o_mem_rd), 32'h1);
        chk("f1_t", 32'(bus.o_t), 32'h0002);
        tick();
        chk("f2_mem_rd", 32'(bus.o_mem_rd), 32'h1);
        tick();
        chk("f3_mem_rd", 32'(bus.o_mem_rd), 32'h1);
        ack(16'h2345);
        chk("dec_ir", 32'(bus.o_ir), 32'h2345);
        chk("dec_pc_inr", 32'(bus.o_pc_inr), 32'h1);
        chk("dec_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        tick();
        chk("ex_ar", 32'(bus.o_ar), 32'h345);
        chk("ex_i", 32'(bus.o_i), 32'h0);
        chk("ex_d", 32'(bus.o_d), 32'h04);
        chk("ex_dec_valid", 32'(bus.o_dec_valid), 32'h1);
        chk("ex_t", 32'(bus.o_t), 32'h0008);
        chk("ex_pc_inr", 32'(bus.o_pc_inr), 32'h0);
        bus.i_exec_done = 1'b1;
        bus.i_pc_q      = 12'h011;
        tick();
        bus.i_exec_done = 1'b0;
        chk("rt0_t", 32'(bus.o_t), 32'h0001);
        chk("rt0_dec_valid", 32'(bus.o_dec_valid), 32'h0);

        // Indirect fetch, then jump+skip together, then skip with done
        tick();
        chk("if_ar", 32'(bus.o_ar), 32'h011);
        ack(16'h9123);
        chk("if_pc_inr", 32'(bus.o_pc_inr), 32'h1);
        tick();
        chk("ind_i", 32'(bus.o_i), 32'h1);
        chk("ind_d", 32'(bus.o_d), 32'h02);
        chk("ind_mem_rd", 32'(bus.o_mem_rd), 32'h1);
        chk("ind_ar", 32'(bus.o_ar), 32'h123);
        ack(16'h0ABC);
        chk("iex_ar", 32'(bus.o_ar), 32'hABC);
        chk("iex_dec_valid", 32'(bus.o_dec_valid), 32'h1);
        chk("iex_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        chk("iex_t", 32'(bus.o_t), 32'h0010);
        bus.i_jmp_req  = 1'b1;
        bus.i_jmp_addr = 12'h0FF;
        bus.i_skip     = 1'b1;
        tick();
        chk("jmp_load", 32'(bus.o_pc_load), 32'h1);
        chk("jmp_data", 32'(bus.o_pc_data), 32'h0FF);
        chk("jmp_inr", 32'(bus.o_pc_inr), 32'h0);
        chk("jmp_dec_valid", 32'(bus.o_dec_valid), 32'h1);
        bus.i_jmp_req   = 1'b0;
        bus.i_exec_done = 1'b1;
        bus.i_pc_q      = 12'h020;
        tick();
        bus.i_skip      = 1'b0;
        bus.i_exec_done = 1'b0;
        chk("skip_inr", 32'(bus.o_pc_inr), 32'h1);
        chk("skip_load", 32'(bus.o_pc_load), 32'h0);
        chk("skip_t", 32'(bus.o_t), 32'h0001);

        // Opcode 7 with I=1 goes straight to EXEC; START low stops after it
        tick();
        ack(16'hF800);
        tick();
        chk("op7_ar", 32'(bus.o_ar), 32'h800);
        chk("op7_i", 32'(bus.o_i), 32'h1);
        chk("op7_d", 32'(bus.o_d), 32'h80);
        chk("op7_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        chk("op7_dec_valid", 32'(bus.o_dec_valid), 32'h1);
        chk("op7_t", 32'(bus.o_t), 32'h0008);
        bus.i_start     = 1'b0;
        bus.i_exec_done = 1'b1;
        tick();
        bus.i_exec_done = 1'b0;
        chk("stop_dec_valid", 32'(bus.o_dec_valid), 32'h0);
        tick();
        tick();
        chk("stop_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        chk("stop_ar", 32'(bus.o_ar), 32'h800);

        // START dropped during FETCH: instruction completes, then IDLE
        bus.i_pc_q  = 12'h030;
        bus.i_start = 1'b1;
        tick();
        tick();
        bus.i_start = 1'b0;
        chk("sd_mem_rd", 32'(bus.o_mem_rd), 32'h1);
        ack(16'h1005);
        tick();
        chk("sd_ar", 32'(bus.o_ar), 32'h005);
        chk("sd_dec_valid", 32'(bus.o_dec_valid), 32'h1);
        bus.i_exec_done = 1'b1;
        tick();
        bus.i_exec_done = 1'b0;
        tick();
        tick();
        chk("sd_idle_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        chk("sd_idle_ar", 32'(bus.o_ar), 32'h005);

        // Ack timeout: 15 read cycles then sticky FAULT
        bus.i_pc_q  = 12'h040;
        bus.i_start = 1'b1;
        tick();
        tick();
        n = 0;
        while (bus.o_mem_rd && n < 40) begin
            n++;
            tick();
        end
        chk("to_rd_cycles", 32'(n), 32'd15);
        chk("to_fault", 32'(bus.o_fault), 32'h1);
        chk("to_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        repeat (4) tick();
        ack(16'h7777);
        tick();
        chk("flt_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        chk("flt_ir", 32'(bus.o_ir), 32'h1005);
        chk("flt_ar", 32'(bus.o_ar), 32'h040);
        chk("flt_sticky", 32'(bus.o_fault), 32'h1);
        #3 clr_n = 1'b0;
        #1;
        chk("clr_fault", 32'(bus.o_fault), 32'h0);
        tick();
        clr_n = 1'b1;

        // Reset mid-FETCH with ack pending: no PC strobe
        tick();
        tick();
        chk("rf_mem_rd", 32'(bus.o_mem_rd), 32'h1);
        chk("rf_ar", 32'(bus.o_ar), 32'h040);
        bus.i_mem_ack  = 1'b1;
        bus.i_mem_data = 16'h3111;
        #2 clr_n = 1'b0;
        #1;
        chk("rf_async_mem_rd", 32'(bus.o_mem_rd), 32'h0);
        chk("rf_async_ar", 32'(bus.o_ar), 32'h0);
        chk("rf_async_t", 32'(bus.o_t), 32'h0001);
        tick();
        chk("rf_pc_inr", 32'(bus.o_pc_inr), 32'h0);
        chk("rf_ir", 32'(bus.o_ir), 32'h0);
        bus.i_mem_ack = 1'b0;
        bus.i_start   = 1'b0;
        clr_n         = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
